// File: rtl/ft60x_fifo_bridge.sv
// ft60x_fifo_bridge: 245-mode synchronous FIFO bridge between an FT600/FT601 chip and on-chip RX/TX FIFOs
module ft60x_fifo_bridge #(
  parameter int DATA_W   = 32,
  parameter int BE_W     = DATA_W / 8,
  parameter int WR_BURST = 1024,
  parameter int RD_BURST = 1024,
  parameter int TURN_CYC = 1,
  parameter int CNT_W    = 13
) (
  input  logic              usb_clk,
  input  logic              rst,
  input  logic              usb_rxf,
  input  logic              usb_txe,
  output logic              usb_rd,
  output logic              usb_oe,
  output logic              usb_wr,
  inout  wire  [DATA_W-1:0] usb_data,
  inout  wire  [BE_W-1:0]   usb_be,
  input  logic [DATA_W-1:0] tx_fifo_data,
  input  logic [BE_W-1:0]   tx_fifo_be,
  input  logic              tx_fifo_empty,
  input  logic              tx_fifo_prog_empty,
  output logic              tx_fifo_read,
  input  logic              rx_fifo_prog_full,
  output logic [DATA_W-1:0] rx_fifo_data,
  output logic [BE_W-1:0]   rx_fifo_be,
  output logic              rx_fifo_write,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, RD_OE, RD, RD_END, WR, TURN} state_t;
  localparam logic [CNT_W-1:0] RD_MAX = CNT_W'(RD_BURST);
  localparam logic [CNT_W-1:0] WR_MAX = CNT_W'(WR_BURST);
  localparam logic [2:0] TURN_LAST = 3'(TURN_CYC - 1);
  state_t state, state_nxt;
  logic [CNT_W-1:0] rd_cnt, wr_cnt;
  logic [2:0] turn_cnt;
  logic prio_tx;
  logic rx_ok, tx_ok, rd_xfer, rd_last, wr_last, turn_entry;
  assign rx_ok        = usb_rxf & ~rx_fifo_prog_full;
  assign tx_ok        = usb_txe & ~tx_fifo_prog_empty & ~tx_fifo_empty;
  assign usb_oe       = state inside {RD_OE, RD, RD_END};
  assign usb_rd       = state == RD;
  assign usb_wr       = state == WR && wr_cnt != WR_MAX;
  assign tx_fifo_read = usb_wr & usb_txe;
  assign usb_data     = state == WR ? tx_fifo_data : {DATA_W{1'bz}};
  assign usb_be       = state == WR ? tx_fifo_be : {BE_W{1'bz}};
  assign busy         = state != IDLE;
  assign rd_xfer      = usb_rd & usb_rxf;
  assign rd_last      = rd_xfer && rd_cnt == RD_MAX - 1'b1;
  assign wr_last      = tx_fifo_read && wr_cnt == WR_MAX - 1'b1;
  assign turn_entry   = state_nxt == TURN && state != TURN;
  // next-state: round-robin arbitration in IDLE, burst exit conditions elsewhere
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (rx_ok && (!tx_ok || !prio_tx)) ? RD_OE : tx_ok ? WR : IDLE;
      RD_OE:   state_nxt = RD;
      RD:      state_nxt = (!usb_rxf || rx_fifo_prog_full || rd_last) ? RD_END : RD;
      RD_END:  state_nxt = TURN;
      WR:      state_nxt = (wr_last || wr_cnt == WR_MAX || !usb_txe || tx_fifo_empty) ? TURN : WR;
      TURN:    state_nxt = turn_cnt == TURN_LAST ? IDLE : TURN;
      default: state_nxt = IDLE;
    endcase
  end
  // state, saturating burst counters, turnaround timer and priority toggle
  always_ff @(posedge usb_clk) begin
    if (rst) begin
      state    <= IDLE;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      turn_cnt <= '0;
      prio_tx  <= 1'b0;
    end else begin
      state    <= state_nxt;
      turn_cnt <= state == TURN ? turn_cnt + 3'd1 : 3'd0;
      if (turn_entry) begin
        rd_cnt  <= '0;
        wr_cnt  <= '0;
        prio_tx <= state == RD_END;
      end else begin
        if (rd_xfer && rd_cnt != RD_MAX) rd_cnt <= rd_cnt + 1'b1;
        if (tx_fifo_read && wr_cnt != WR_MAX) wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end
  // RX write strobe lags each bus transfer by one edge; reset suppresses a pending one
  always_ff @(posedge usb_clk) begin
    rx_fifo_write <= !rst && rd_xfer;
  end
  // RX sample register, loaded only on a real transfer
  always_ff @(posedge usb_clk) begin
    if (rd_xfer) begin
      rx_fifo_data <= usb_data;
      rx_fifo_be   <= usb_be;
    end
  end
endmodule

// File: doc/ft60x_fifo_bridge.md
Name: ft60x_fifo_bridge

Overview:
Parametrised synchronous 245-mode FIFO bridge between an FT600/FT601-class USB 3.0 FIFO chip and two on-chip FIFOs: an RX FIFO written with host→FPGA data and a show-ahead TX FIFO read for FPGA→host data.
- Bus width is selectable (16/32 bit).
- Read and write bursts have independent length limits.
- Direction arbitration is round-robin.
- Bus turnaround time is configurable.
- Byte enables are carried per word.
- Write bursts survive usb_txe dropping mid-burst without data loss.

Parameters:
- DATA_W, 32, bus width in bits; legal values 16 or 32.
- BE_W, DATA_W/8, byte-enable width.
- WR_BURST, 1024, max words per write burst; range 1..4096.
- RD_BURST, 1024, max words per read burst before the bridge yields; range 1..4096.
- TURN_CYC, 1, idle cycles with the bus released between bursts; range 1..7.
- CNT_W, 13, width of the burst counters; must satisfy 2^CNT_W > max(WR_BURST, RD_BURST).

Ports:
- usb_clk  in  1  chip-supplied clock; all logic is on this clock.
- rst  in  1  synchronous, active-high reset.
- usb_rxf  in  1  high = chip holds data for the FPGA.
- usb_txe  in  1  high = chip can accept data.
- usb_rd  out  1  high = read strobe.
- usb_oe  out  1  high = chip drives the bus.
- usb_wr  out  1  high = write strobe.
- usb_data  inout  DATA_W  bidirectional data bus.
- usb_be  inout  BE_W  bidirectional byte enables.
- tx_fifo_data  in  DATA_W  show-ahead head word.
- tx_fifo_be  in  BE_W  byte enables of the head word.
- tx_fifo_empty  in  1  TX FIFO empty.
- tx_fifo_prog_empty  in  1  high = fewer than WR_BURST words available.
- tx_fifo_read  out  1  pop the head word.
- rx_fifo_prog_full  in  1  high = fewer than 4 free slots.
- rx_fifo_data  out  DATA_W  word to write.
- rx_fifo_be  out  BE_W  byte enables of that word.
- rx_fifo_write  out  1  write strobe.
- busy  out  1  high when state is not IDLE.

Behaviour:
Reset:
- Applies on the first usb_clk edge with rst=1.
- usb_rd, usb_oe, usb_wr, tx_fifo_read, rx_fifo_write and busy are 0.
- usb_data and usb_be are hi-Z.
- Counters are 0; priority is set to RX; state is IDLE.
- Reset mid-burst aborts the burst: all strobes drop at that edge and no FIFO strobe follows.

State machine (IDLE, RD_OE, RD, RD_END, WR, TURN):
- IDLE:
  - rx_ok = usb_rxf & !rx_fifo_prog_full.
  - tx_ok = usb_txe & !tx_fifo_prog_empty & !tx_fifo_empty.
  - If both are ok, the priority direction wins. Otherwise the single ok direction is taken; if none, stay in IDLE.
  - RX goes to RD_OE; TX goes to WR.
- RD_OE: usb_oe=1, usb_rd=0. Lasts one cycle, then RD.
- RD:
  - usb_oe=1 and usb_rd=1.
  - A word transfers on each edge where usb_rd & usb_rxf; rd_cnt increments on each transfer.
  - Exit to RD_END when usb_rxf=0, rx_fifo_prog_full=1, or rd_cnt reaches RD_BURST on this transfer.
- RD_END: usb_rd=0 and usb_oe=1 for one cycle, then TURN.
- WR:
  - usb_data is driven with tx_fifo_data and usb_be with tx_fifo_be, combinationally.
  - usb_wr = (wr_cnt != WR_BURST).
  - tx_fifo_read = usb_wr & usb_txe, combinationally. The word is accepted and popped in the same cycle.
  - Exit to TURN when wr_cnt reaches WR_BURST, when usb_txe=0 (unaccepted words stay in the FIFO), or when tx_fifo_empty=1.
- TURN:
  - All strobes are 0 and the bus is hi-Z for TURN_CYC cycles, then IDLE.
  - Priority toggles to the direction not just served.
  - rd_cnt and wr_cnt clear on TURN entry.

RX datapath:
- The sample is registered: rx_fifo_data, rx_fifo_be and rx_fifo_write=1 appear one cycle after each transfer edge.
- rx_fifo_write is never asserted for an edge with usb_rxf=0.
- The 4-slot prog_full margin covers the pipeline plus exit latency.

Bus ownership:
- The FPGA drives the bus only in WR.
- usb_oe is never high in WR, TURN or IDLE.
- usb_wr and usb_oe are never high in the same cycle.

Counters:
- CNT_W bits, saturating at their limit.
- They never wrap during a burst.

Test Plan:
1. Reset with rxf=txe=0, then release → all outputs 0, bus hi-Z, busy=0; 5 cycles later still IDLE.
2. RX only: rxf held 1 for 10 words of 0x00000001..0x0000000A, be=4'hF, RD_BURST=1024 → oe rises 1 cycle before rd; rxf drops after word 10. Expect 10 rx_fifo_write pulses with data in order, each lagging its transfer edge by 1; then RD_END, and TURN for TURN_CYC cycles.
3. TX full burst, WR_BURST=16, txe=1, 64 words queued → exactly 16 usb_wr cycles and 16 tx_fifo_read pulses with data/be matching the FIFO; 48 words remain.
4. TX stall: txe forced 0 after word 5 of a 16-word burst → exactly 5 pops, exit to TURN. The next burst starts with word 6 unchanged, with no duplication or loss.
5. Contention: rxf=1 and tx_ok both held continuously, RD_BURST=WR_BURST=8 → bursts alternate RX, TX, RX, TX of 8 words each. The bus is hi-Z for exactly TURN_CYC cycles between bursts, and oe/wr never overlap.
6. rx_fifo_prog_full rises mid-read at word 3 → at most 3 more words are written; rd drops next edge; the bridge does not re-enter RD_OE until prog_full=0. Separately, rst asserted mid-WR → strobes drop at that edge and the bus is hi-Z.
